// File: rtl/recv_pkt_fifo_if.sv
// Ingress Avalon-ST sink plus the show-ahead reader port that recv_pkt_fifo presents to mspe.
// master = packet source / reader side, slave = the FIFO itself.
interface recv_pkt_fifo_if #(
    parameter int DATA_W     = 512,
    parameter int DEPTH_LOG2 = 10
);
    logic [DATA_W-1:0]   snk_data;
    logic                snk_valid;
    logic                snk_sop;
    logic                snk_eop;
    logic                snk_ready;

    logic                recv_fifo_rdreq;
    logic [DATA_W-1:0]   recv_fifo_q;
    logic [DEPTH_LOG2:0] recv_fifo_rdusedw;
    logic                recv_fifo_valid;

    modport master (
        output snk_data, snk_valid, snk_sop, snk_eop, recv_fifo_rdreq,
        input  snk_ready, recv_fifo_q, recv_fifo_rdusedw, recv_fifo_valid
    );

    modport slave (
        input  snk_data, snk_valid, snk_sop, snk_eop, recv_fifo_rdreq,
        output snk_ready, recv_fifo_q, recv_fifo_rdusedw, recv_fifo_valid
    );
endinterface

// File: rtl/recv_pkt_fifo.sv
// Packet-granular ingress FIFO in front of mspe: whole packets are admitted or dropped at SOP,
// beats become visible two edges after acceptance, and the reader sees a show-ahead head beat.
module recv_pkt_fifo #(
    parameter int DATA_W        = 512,
    parameter int DEPTH_LOG2    = 10,
    parameter int MAX_PKT_BEATS = 64,
    parameter     DEVICE        = "ARTIX7"
) (
    input  logic               clk,
    input  logic               reset,
    recv_pkt_fifo_if.slave     bus,
    output logic [31:0]        drop_count,
    output logic [15:0]        proto_err_count,
    output logic               overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int OCC_W = DEPTH_LOG2 + 2;
    localparam logic [OCC_W-1:0] FULL_LEVEL  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ADMIT_LIMIT = OCC_W'(DEPTH - MAX_PKT_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } wr_state_t;

    wr_state_t           state;

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic                s2_valid;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0] used;
    logic [OCC_W-1:0]    occ;
    logic                has_room;
    logic                fifo_full;
    logic                pop;
    logic [DATA_W-1:0]   head_data;

    // In-flight beats (s1, s2) already own a slot, so they count against free space.
    assign occ       = OCC_W'(used) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
    assign has_room  = (occ <= ADMIT_LIMIT);
    assign fifo_full = (occ >= FULL_LEVEL);
    assign pop       = bus.recv_fifo_rdreq && (used != '0);

    assign bus.snk_ready         = !reset;
    assign bus.recv_fifo_rdusedw = used;
    assign bus.recv_fifo_valid   = (used != '0);
    assign bus.recv_fifo_q       = (used != '0) ? head_data : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every register in this
    // block samples pre-edge values and the block order cannot change behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            s1_valid        <= 1'b0;
            drop_count      <= '0;
            proto_err_count <= '0;
            overflow        <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (bus.snk_valid) begin
                if (bus.snk_sop && state != IDLE && proto_err_count != '1) begin
                    proto_err_count <= proto_err_count + 16'd1;
                end
                if (state == PASS) begin
                    // A stray SOP inside a packet is still stored; only a full FIFO loses beats.
                    if (fifo_full) begin
                        overflow <= 1'b1;
                    end else begin
                        s1_valid <= 1'b1;
                    end
                    if (bus.snk_eop) begin
                        state <= IDLE;
                    end
                end else if (bus.snk_sop) begin
                    // Fresh SOP from IDLE, or a restart from DROP: admission decided here.
                    if (has_room) begin
                        s1_valid <= 1'b1;
                        state    <= bus.snk_eop ? IDLE : PASS;
                    end else begin
                        if (drop_count != '1) begin
                            drop_count <= drop_count + 32'd1;
                        end
                        state <= bus.snk_eop ? IDLE : DROP;
                    end
                end else if (state == DROP) begin
                    if (bus.snk_eop) begin
                        state <= IDLE;
                    end
                end else if (proto_err_count != '1) begin
                    proto_err_count <= proto_err_count + 16'd1;
                end
            end
        end
    end

    // Datapath capture needs no reset; s1_valid qualifies it.
    always_ff @(posedge clk) begin
        if (bus.snk_valid) begin
            s1_data <= bus.snk_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            used     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A beat written last edge becomes visible now; a simultaneous pop cancels it out.
            case ({s2_valid, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    generate
        if (DEVICE == "ARTIX7") begin : g_mem_artix7
            logic [DATA_W-1:0] mem [DEPTH];

            // NOTE: the storage array is deliberately not reset; emptiness is tracked by
            // the pointers and used count, and a resettable array would not map to RAM.
            always_ff @(posedge clk) begin
                if (s1_valid && !reset) begin
                    mem[wr_ptr] <= s1_data;
                end
            end

            assign head_data = mem[rd_ptr];
        end else begin : g_mem_generic
            logic [DATA_W-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (s1_valid && !reset) begin
                    mem[wr_ptr] <= s1_data;
                end
            end

            assign head_data = mem[rd_ptr];
        end
    endgenerate

endmodule

// File: tb/tb_recv_pkt_fifo.sv
// Directed + randomized bench for recv_pkt_fifo against a queue-based reference model.
module tb_recv_pkt_fifo;
    localparam int DATA_W     = 512;
    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int MAX_PKT    = 64;

    localparam int M_IDLE = 0;
    localparam int M_PASS = 1;
    localparam int M_DROP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] drop_count;
    logic [15:0] proto_err_count;
    logic        overflow;

    recv_pkt_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    recv_pkt_fifo #(
        .DATA_W(DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .MAX_PKT_BEATS(MAX_PKT),
        .DEVICE("ARTIX7")
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .drop_count(drop_count),
        .proto_err_count(proto_err_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                ready_at;
    } pend_t;

    int                n_assert = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    logic [DATA_W-1:0] vis[$];
    pend_t             pend[$];
    int                m_mode = M_IDLE;
    longint            m_drop = 0;
    int                m_perr = 0;
    bit                m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_beat();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Spec rules: packet admitted whole if >= MAX_PKT free at SOP, else dropped and counted.
    task automatic model_accept(input int occ);
        logic [DATA_W-1:0] d = bus.snk_data;
        bit sop = bus.snk_sop;
        bit eop = bus.snk_eop;
        if (sop && m_mode != M_IDLE && m_perr < 65535) m_perr++;
        if (m_mode == M_PASS) begin
            if (occ >= DEPTH) m_ovf = 1'b1;
            else pend.push_back('{d, cyc + 2});
            if (eop) m_mode = M_IDLE;
        end else if (sop) begin
            if (DEPTH - occ >= MAX_PKT) begin
                pend.push_back('{d, cyc + 2});
                m_mode = eop ? M_IDLE : M_PASS;
            end else begin
                if (m_drop < 64'hFFFF_FFFF) m_drop++;
                m_mode = eop ? M_IDLE : M_DROP;
            end
        end else if (m_mode == M_DROP) begin
            if (eop) m_mode = M_IDLE;
        end else if (m_perr < 65535) begin
            m_perr++;
        end
    endtask

    task automatic edge_step();
        int occ;
        bit pop;
        @(posedge clk);
        cyc++;
        if (reset) begin
            vis.delete();
            pend.delete();
            m_mode = M_IDLE;
            m_drop = 0;
            m_perr = 0;
            m_ovf  = 1'b0;
        end else begin
            occ = vis.size() + pend.size();
            pop = bus.recv_fifo_rdreq && vis.size() != 0;
            if (bus.snk_valid) model_accept(occ);
            if (pop) void'(vis.pop_front());
            while (pend.size() != 0 && pend[0].ready_at <= cyc) begin
                vis.push_back(pend[0].d);
                void'(pend.pop_front());
            end
        end
        #1;
        check("rdusedw", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(vis.size()));
        check("valid", DATA_W'(bus.recv_fifo_valid), DATA_W'(vis.size() != 0));
        check("q", bus.recv_fifo_q, (vis.size() != 0) ? vis[0] : '0);
        check("drop_count", DATA_W'(drop_count), DATA_W'(m_drop));
        check("proto_err_count", DATA_W'(proto_err_count), DATA_W'(m_perr));
        check("overflow", DATA_W'(overflow), DATA_W'(m_ovf));
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input bit sop, input bit eop, input bit rd);
        bus.snk_data        = d;
        bus.snk_valid       = 1'b1;
        bus.snk_sop         = sop;
        bus.snk_eop         = eop;
        bus.recv_fifo_rdreq = rd;
        edge_step();
    endtask

    task automatic idle(input int n, input bit rd);
        bus.snk_valid       = 1'b0;
        bus.snk_sop         = 1'b0;
        bus.snk_eop         = 1'b0;
        bus.recv_fifo_rdreq = rd;
        repeat (n) edge_step();
    endtask

    task automatic send_pkt(input int len, input bit rd);
        for (int i = 0; i < len; i++) beat(rand_beat(), i == 0, i == len - 1, rd);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 16 && (vis.size() + pend.size()) != 0; i++) idle(1, 1'b1);
        idle(1, 1'b0);
        check("drain_empty", DATA_W'(bus.recv_fifo_rdusedw), '0);
    endtask

    initial begin
        logic [DATA_W-1:0] b0;

        bus.snk_data        = '0;
        bus.snk_valid       = 1'b0;
        bus.snk_sop         = 1'b0;
        bus.snk_eop         = 1'b0;
        bus.recv_fifo_rdreq = 1'b0;
        reset               = 1'b1;
        edge_step();
        edge_step();
        check("ready_in_reset", DATA_W'(bus.snk_ready), '0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", DATA_W'(bus.snk_ready), DATA_W'(1));

        // Two-edge visibility latency on an empty FIFO
        b0 = rand_beat();
        b0[31:0]  = 32'd32;
        b0[63:32] = 32'd3;
        beat(b0, 1'b1, 1'b0, 1'b0);
        beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        beat(rand_beat(), 1'b0, 1'b1, 1'b0);
        check("t1_valid", DATA_W'(bus.recv_fifo_valid), DATA_W'(1));
        check("t1_q_lo", DATA_W'(bus.recv_fifo_q[31:0]), DATA_W'(32));
        check("t1_q_hi", DATA_W'(bus.recv_fifo_q[63:32]), DATA_W'(3));
        idle(2, 1'b0);
        check("t1_rdusedw3", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(3));
        drain();

        // Reads on an empty FIFO are ignored
        for (int i = 0; i < 10; i++) begin
            idle(1, 1'b1);
            check("t4_empty_used", DATA_W'(bus.recv_fifo_rdusedw), '0);
            check("t4_empty_valid", DATA_W'(bus.recv_fifo_valid), '0);
        end
        send_pkt(3, 1'b0);
        idle(2, 1'b0);
        drain();

        // Admission threshold: free=63 drops, free=64 accepts
        for (int p = 0; p < 15; p++) send_pkt(64, 1'b0);
        send_pkt(1, 1'b0);
        idle(2, 1'b0);
        check("t2_preload", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(961));
        send_pkt(4, 1'b0);
        idle(2, 1'b0);
        check("t2_drop", DATA_W'(drop_count), DATA_W'(1));
        check("t2_level", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(961));
        idle(1, 1'b1);
        check("t2_pop", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(960));
        send_pkt(4, 1'b0);
        idle(2, 1'b0);
        check("t2_accept", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(964));
        check("t2_drop_same", DATA_W'(drop_count), DATA_W'(1));
        drain();

        // Over-length packet fills the FIFO to 1024 and sets sticky overflow
        for (int p = 0; p < 15; p++) send_pkt(64, 1'b0);
        send_pkt(70, 1'b0);
        idle(2, 1'b0);
        check("ovf_set", DATA_W'(overflow), DATA_W'(1));
        check("ovf_full", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(DEPTH));
        drain();

        // Steady stream with concurrent pops holds level at 5
        send_pkt(5, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 40; i++) begin
            beat(rand_beat(), (i % 8) == 0, (i % 8) == 7, i >= 2);
            check("t3_level", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(5));
        end
        drain();

        // Framing errors: unframed beat in IDLE, stray SOP in PASS
        beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        beat(rand_beat(), 1'b1, 1'b0, 1'b0);
        beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        beat(rand_beat(), 1'b1, 1'b0, 1'b0);
        beat(rand_beat(), 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        check("t5_perr", DATA_W'(proto_err_count), DATA_W'(2));
        check("t5_stored", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(4));
        drain();

        // Reset in the middle of a packet
        beat(rand_beat(), 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        check("t6_ready", DATA_W'(bus.snk_ready), '0);
        check("t6_used", DATA_W'(bus.recv_fifo_rdusedw), '0);
        check("t6_valid", DATA_W'(bus.recv_fifo_valid), '0);
        check("t6_q", bus.recv_fifo_q, '0);
        check("t6_ovf", DATA_W'(overflow), '0);
        check("t6_drop", DATA_W'(drop_count), '0);
        reset = 1'b0;
        beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        beat(rand_beat(), 1'b0, 1'b1, 1'b0);
        check("t6_perr", DATA_W'(proto_err_count), DATA_W'(3));
        send_pkt(3, 1'b0);
        idle(2, 1'b0);
        check("t6_next_pkt", DATA_W'(bus.recv_fifo_rdusedw), DATA_W'(3));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
